// File: rtl/etapa_if.sv
`default_nettype none
// ============================================================================
// Module      : etapa_if
// Description : MIPS instruction-fetch stage: PC, word-addressed instruction
//               memory with loader port, IF/ID register and sticky HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module etapa_if #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 64,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_stall,
    input  logic                  i_pcsrc,
    input  logic [DATA_WIDTH-1:0] i_pcbranch,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_pc4,
    output logic                  o_halt
);

    localparam logic [DATA_WIDTH-1:0] c_pc_step = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] c_nop     = '0;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [DATA_WIDTH-1:0] r_pc_q,    w_pc_d;
    logic [DATA_WIDTH-1:0] r_instr_q, w_instr_d;
    logic [DATA_WIDTH-1:0] r_pc4_q,   w_pc4_d;
    logic                  r_halt_q,  w_halt_d;

    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [DATA_WIDTH-1:0] w_fetch;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic                  w_fetch_is_halt;

    // Loader port is independent of run control so a program can be
    // patched while the core is frozen or halted.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Word index drops the byte-offset bits; upper PC bits wrap the index.
    assign w_rd_idx        = r_pc_q[ADDR_WIDTH+1:2];
    assign w_fetch         = r_mem[w_rd_idx];
    assign w_pc_plus4      = r_pc_q + c_pc_step;
    assign w_fetch_is_halt = (w_fetch == HALT_WORD);

    always_comb begin
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        w_pc4_d   = r_pc4_q;
        w_halt_d  = r_halt_q;

        if (i_enable) begin
            // PC: halt freezes fetch; a redirect overrides a pending stall.
            if (r_halt_q) begin
                w_pc_d = r_pc_q;
            end else if (i_pcsrc) begin
                w_pc_d = i_pcbranch;
            end else if (i_stall) begin
                w_pc_d = r_pc_q;
            end else if (w_fetch_is_halt) begin
                w_pc_d = r_pc_q;
            end else begin
                w_pc_d = w_pc_plus4;
            end

            // IF/ID: a flush discards the fetched word, including a HALT.
            if (i_pcsrc) begin
                w_instr_d = c_nop;
                w_pc4_d   = c_nop;
            end else if (i_stall) begin
                w_instr_d = r_instr_q;
                w_pc4_d   = r_pc4_q;
            end else if (r_halt_q) begin
                w_instr_d = c_nop;
            end else begin
                w_instr_d = w_fetch;
                w_pc4_d   = w_pc_plus4;
                if (w_fetch_is_halt) begin
                    w_halt_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pc_q    <= '0;
            r_instr_q <= c_nop;
            r_pc4_q   <= '0;
            r_halt_q  <= 1'b0;
        end else begin
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
            r_pc4_q   <= w_pc4_d;
            r_halt_q  <= w_halt_d;
        end
    end

    assign o_pc          = r_pc_q;
    assign o_instruccion = r_instr_q;
    assign o_pc4         = r_pc4_q;
    assign o_halt        = r_halt_q;

endmodule
`default_nettype wire

// File: tb/tb_etapa_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_etapa_if
// Description : Directed self-checking bench for etapa_if with a scoreboard
//               of expected IF-stage outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_etapa_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic        i_stall;
    logic        i_pcsrc;
    logic [31:0] i_pcbranch;
    logic        i_wr_en;
    logic [5:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic [31:0] o_pc;
    logic [31:0] o_instruccion;
    logic [31:0] o_pc4;
    logic        o_halt;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    etapa_if dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (i_enable),
        .i_stall      (i_stall),
        .i_pcsrc      (i_pcsrc),
        .i_pcbranch   (i_pcbranch),
        .i_wr_en      (i_wr_en),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .o_pc         (o_pc),
        .o_instruccion(o_instruccion),
        .o_pc4        (o_pc4),
        .o_halt       (o_halt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [31:0] pc4,
                        input logic halt);
        exp_t e;
        e.tag  = tag;
        e.pc   = pc;
        e.ins  = ins;
        e.pc4  = pc4;
        e.halt = halt;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "pc",    o_pc,          e.pc);
        cmp(e.tag, "instr", o_instruccion, e.ins);
        cmp(e.tag, "pc4",   o_pc4,         e.pc4);
        cmp(e.tag, "halt",  {31'd0, o_halt}, {31'd0, e.halt});
    endtask

    // One clock: drive controls, queue the expected result, compare after the edge.
    task automatic step(input string tag, input logic en, input logic st,
                        input logic ps, input logic [31:0] br,
                        input logic [31:0] e_pc, input logic [31:0] e_ins,
                        input logic [31:0] e_pc4, input logic e_h);
        i_enable   = en;
        i_stall    = st;
        i_pcsrc    = ps;
        i_pcbranch = br;
        push(tag, e_pc, e_ins, e_pc4, e_h);
        @(posedge clk);
        #1;
        i_wr_en = 1'b0;
        pop_check();
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        i_wr_en   = 1'b1;
        i_wr_addr = a;
        i_wr_data = d;
        @(posedge clk);
        #1;
        i_wr_en = 1'b0;
    endtask

    // Asynchronous reset pulse asserted mid-cycle, checked before the next edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        push(tag, 32'h0, 32'h0, 32'h0, 1'b0);
        pop_check();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] prog [4];
        prog[0] = 32'h20010005;
        prog[1] = 32'h20020007;
        prog[2] = 32'h00221820;
        prog[3] = 32'hFFFFFFFF;

        rst        = 1'b1;
        i_enable   = 1'b0;
        i_stall    = 1'b0;
        i_pcsrc    = 1'b0;
        i_pcbranch = 32'h0;
        i_wr_en    = 1'b0;
        i_wr_addr  = 6'd0;
        i_wr_data  = 32'h0;
        #1;
        push("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        pop_check();

        for (int i = 0; i < 64; i++) begin
            load(6'(i), (i < 4) ? prog[i] : (32'h10000000 | 32'(i)));
        end
        rst = 1'b0;

        // Straight-line run into HALT
        step("run0", 1, 0, 0, 0, 32'h4, 32'h20010005, 32'h4,  0);
        step("run1", 1, 0, 0, 0, 32'h8, 32'h20020007, 32'h8,  0);
        step("run2", 1, 0, 0, 0, 32'hC, 32'h00221820, 32'hC,  0);
        step("halt", 1, 0, 0, 0, 32'hC, 32'hFFFFFFFF, 32'h10, 1);
        step("nop1", 1, 0, 0, 0, 32'hC, 32'h0,        32'h10, 1);
        step("nop2", 1, 0, 0, 0, 32'hC, 32'h0,        32'h10, 1);

        // Two-cycle stall at PC=8
        do_reset("rst_a");
        step("s_run0", 1, 0, 0, 0, 32'h4, 32'h20010005, 32'h4, 0);
        step("s_run1", 1, 0, 0, 0, 32'h8, 32'h20020007, 32'h8, 0);
        step("stall1", 1, 1, 0, 0, 32'h8, 32'h20020007, 32'h8, 0);
        step("stall2", 1, 1, 0, 0, 32'h8, 32'h20020007, 32'h8, 0);
        step("resume", 1, 0, 0, 0, 32'hC, 32'h00221820, 32'hC, 0);

        // Redirect wins over stall
        do_reset("rst_b");
        step("b_run0",  1, 0, 0, 0,     32'h4,  32'h20010005, 32'h4,  0);
        step("br_stl",  1, 1, 1, 32'h20, 32'h20, 32'h0,        32'h0,  0);
        step("br_next", 1, 0, 0, 0,     32'h24, 32'h10000008, 32'h24, 0);

        // Flush discards a fetched HALT
        do_reset("rst_c");
        step("f_run0",  1, 0, 0, 0,     32'h4,  32'h20010005, 32'h4,  0);
        step("f_run1",  1, 0, 0, 0,     32'h8,  32'h20020007, 32'h8,  0);
        step("f_run2",  1, 0, 0, 0,     32'hC,  32'h00221820, 32'hC,  0);
        step("f_flush", 1, 0, 1, 32'h14, 32'h14, 32'h0,        32'h0,  0);
        step("f_next",  1, 0, 0, 0,     32'h18, 32'h10000005, 32'h18, 0);

        // Freeze for 3 cycles with a loader write, then run through PC wrap
        step("dis1", 0, 0, 0, 0, 32'h18, 32'h10000005, 32'h18, 0);
        i_wr_en   = 1'b1;
        i_wr_addr = 6'd2;
        i_wr_data = 32'h2003000A;
        step("dis2", 0, 1, 1, 32'h40, 32'h18, 32'h10000005, 32'h18, 0);
        step("dis3", 0, 0, 0, 0, 32'h18, 32'h10000005, 32'h18, 0);
        for (int k = 0; k < 58; k++) begin
            step("walk", 1, 0, 0, 0, 32'h1C + 32'(4 * k),
                 32'h10000000 | 32'(6 + k), 32'h1C + 32'(4 * k), 0);
        end
        step("wrap0", 1, 0, 0, 0, 32'h104, 32'h20010005, 32'h104, 0);
        i_wr_en   = 1'b1;
        i_wr_addr = 6'd1;
        i_wr_data = 32'h20020009;
        step("rw_old", 1, 0, 0, 0, 32'h108, 32'h20020007, 32'h108, 0);
        step("wr_vis", 1, 0, 0, 0, 32'h10C, 32'h2003000A, 32'h10C, 0);

        // Reset while stalled at PC=0x10, then re-run the patched image
        do_reset("rst_d");
        step("d_run0",  1, 0, 0, 0,     32'h4,  32'h20010005, 32'h4, 0);
        step("d_run1",  1, 0, 0, 0,     32'h8,  32'h20020009, 32'h8, 0);
        step("d_br",    1, 0, 1, 32'h10, 32'h10, 32'h0,        32'h0, 0);
        step("d_stall", 1, 1, 0, 0,     32'h10, 32'h0,        32'h0, 0);
        do_reset("rst_mid");
        step("e_run0", 1, 0, 0, 0, 32'h4, 32'h20010005, 32'h4,  0);
        step("e_run1", 1, 0, 0, 0, 32'h8, 32'h20020009, 32'h8,  0);
        step("e_run2", 1, 0, 0, 0, 32'hC, 32'h2003000A, 32'hC,  0);
        step("e_halt", 1, 0, 0, 0, 32'hC, 32'hFFFFFFFF, 32'h10, 1);
        step("e_nop",  1, 0, 1, 32'h40, 32'hC, 32'h0,   32'h0,  1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/etapa_if.md
Name: etapa_if

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: program counter, word-addressed instruction memory, and the IF/ID pipeline register.
- Its registered instruction output feeds the ID stage directly. The ID-stage sign extender takes bits [15:0] of that word to form the 32-bit branch offset.
- Also handles hazard stall, branch redirect/flush, debug-unit step enable, program loading, and HALT detection.

Parameters:
- DATA_WIDTH, 32, instruction/PC width in bits.
- MEM_DEPTH, 64, instruction memory depth in words.
- ADDR_WIDTH, 6, word-index width; must equal log2(MEM_DEPTH).
- HALT_WORD, 32'hFFFFFFFF, encoding that stops fetch.

Ports:
- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  run/step enable from the debug unit; 0 freezes all state.
- i_stall  in  1  load-use hazard stall from the hazard unit.
- i_pcsrc  in  1  branch/jump taken, resolved in ID.
- i_pcbranch  in  DATA_WIDTH  redirect target PC.
- i_wr_en  in  1  loader write strobe.
- i_wr_addr  in  ADDR_WIDTH  loader word address.
- i_wr_data  in  DATA_WIDTH  loader instruction word.
- o_pc  out  DATA_WIDTH  current PC (debug).
- o_instruccion  out  DATA_WIDTH  IF/ID instruction, consumed by decode and the sign extender.
- o_pc4  out  DATA_WIDTH  IF/ID PC+4.
- o_halt  out  1  sticky halt flag.

Behaviour:
- Reset (asynchronous, immediate): PC=0, o_instruccion=0 (NOP), o_pc4=0, o_halt=0. Memory contents are not reset.
- Memory write: synchronous write on i_wr_en at the rising edge, accepted regardless of i_enable or halt.
- Memory read: combinational at index PC[ADDR_WIDTH+1:2]. PC bits [1:0] are ignored.
- Index wrap: the index wraps modulo MEM_DEPTH. Example: with defaults, PC=0x100 reads word 0.
- Read/write same cycle, same address: the fetched word latched at that edge is the old data.
- PC update per edge, highest priority first:
  - i_enable=0 → hold.
  - o_halt=1 → hold.
  - i_pcsrc=1 → PC=i_pcbranch. Redirect wins over stall.
  - i_stall=1 → hold.
  - Otherwise PC=PC+4. Arithmetic is modulo 2^DATA_WIDTH; 0xFFFFFFFC wraps to 0.
- IF/ID register update per edge, highest priority first:
  - i_enable=0 → hold.
  - i_pcsrc=1 (flush) → o_instruccion=0, o_pc4=0.
  - i_stall=1 → hold.
  - o_halt=1 → o_instruccion=0, o_pc4 holds.
  - Otherwise o_instruccion=mem[idx], o_pc4=PC+4.
- HALT: when the fetched word equals HALT_WORD and the IF/ID register loads it (enable=1, no flush, no stall):
  - HALT_WORD is latched into o_instruccion.
  - o_halt=1 from that same edge, sticky until reset.
  - PC stays at the HALT address.
  - Following cycles insert NOPs.
- Flushed HALT: a HALT word fetched in a flush cycle is discarded and does not set o_halt.
- Latency: the instruction at PC appears on o_instruccion 1 cycle after PC is presented.
- Reset mid-run or mid-stall: all registered state returns to reset values immediately; the memory image is preserved.

Test Plan:
- Load mem[0..3]=0x20010005, 0x20020007, 0x00221820, 0xFFFFFFFF; release reset with enable=1 → o_instruccion sequence 0x20010005, 0x20020007, 0x00221820, 0xFFFFFFFF with o_pc4=4, 8, 0xC, 0x10; o_halt=1 at the 4th edge; PC stays 0xC; o_instruccion=0 afterwards.
- Assert stall for 2 cycles while PC=8 → PC stays 8 and o_instruccion holds 0x20020007 for 2 cycles; then resumes with 0x00221820.
- Assert stall and pcsrc together with pcbranch=0x20 at PC=4 → next PC=0x20, o_instruccion=0, o_pc4=0; the following edge fetches mem[8].
- Flush while the fetched word is HALT_WORD → o_halt stays 0 and fetch continues from pcbranch.
- Set enable=0 for 3 cycles mid-run → PC, o_instruccion, o_pc4 unchanged; a loader write during that window is visible after PC wraps back to the written address.
- Assert reset asynchronously mid-cycle while stalled at PC=0x10 → PC=0, o_instruccion=0, o_halt=0 before the next edge; the memory image is unchanged on re-run. Also check the wrap case: PC=0xFC advances to 0x100 and reads word 0.
